sha256_compress: RTL and testbench

SHA-256 compression engine: the stage directly downstream of the message scheduler. It consumes the 64 scheduled 32-bit words W0..W63 of each 512-bit block, one per accepted cycle, and runs the 64 FIPS 180-4 §6.2.2 rounds on working variables a..h. It then adds the result into the running hash H0..H7. It supports multi-block messages by chaining the intermediate hash, and presents the 256-bit digest after the block flagged as last.

---
 rtl/sha256_pkg.sv | 66 ++++++
 rtl/sha256_compress_round.sv | 27 ++
 rtl/sha256_compress.sv | 105 ++++++++++
 tb/tb_sha256_compress.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions for the compression engine and the message
// scheduler: round constants K, initial hash IV, the logical functions
// (Ch, Maj, big and small sigmas) and the compression FSM state encodings.
package sha256_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Sigma0 = ROTR2 ^ ROTR13 ^ ROTR22
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Sigma1 = ROTR6 ^ ROTR11 ^ ROTR25
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3 (message scheduler)
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10 (message scheduler)
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_round.sv
// sha256_round
// One combinational SHA-256 compression round.
// Ports:
//   vars_in  [255:0]  working variables {a,b,c,d,e,f,g,h}, a in [255:224]
//   k        [31:0]   round constant K[t]
//   w        [31:0]   scheduled word W[t]
//   vars_out [255:0]  working variables after the round, same packing
import sha256_pkg::*;

module sha256_round (
  input  logic [255:0] vars_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] vars_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = vars_in;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign vars_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress
// SHA-256 compression engine. Accepts 64 scheduled words per block, one per
// cycle with w_valid, runs the 64 rounds, adds the result into the running
// hash and publishes the digest after a block flagged as last.
// Ports:
//   clk, reset (async, active-high)
//   block_start  pulse to begin a block (only honoured in IDLE)
//   first_block  with block_start: 1 = start from IV, 0 = chain from current H
//   last_block   with block_start: 1 = publish digest at completion
//   w_valid/w_in next scheduled word (only honoured in ROUND)
//   busy         high in ROUND, FINAL and DONE
//   done         one-cycle pulse at block completion
//   digest_valid high from completion of a last block until next block_start
//   digest       {H0..H7}, forced to 0 unless digest_valid
import sha256_pkg::*;

module sha256_compress (
  input  logic         clk,
  input  logic         reset,
  input  logic         block_start,
  input  logic         first_block,
  input  logic         last_block,
  input  logic         w_valid,
  input  logic [31:0]  w_in,
  output logic         busy,
  output logic         done,
  output logic         digest_valid,
  output logic [255:0] digest
);

  logic [1:0]   state;
  logic [5:0]   t;
  logic [255:0] work;
  logic [255:0] work_next;
  logic [255:0] hash;
  logic [255:0] hash_sum;
  logic [255:0] iv_flat;
  logic         last_latched;

  assign iv_flat = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  sha256_round u_round (
    .vars_in  (work),
    .k        (K[t]),
    .w        (w_in),
    .vars_out (work_next)
  );

  // Final feed-forward: each Hi picks up its matching working variable.
  for (genvar i = 0; i < 8; i++) begin : g_sum
    assign hash_sum[i*32 +: 32] = hash[i*32 +: 32] + work[i*32 +: 32];
  end

  // digest_valid is set on the FINAL->DONE edge so it rises together with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      t            <= '0;
      work         <= '0;
      hash         <= '0;
      last_latched <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (block_start) begin
            state        <= ROUND;
            t            <= '0;
            last_latched <= last_block;
            digest_valid <= 1'b0;
            if (first_block) begin
              work <= iv_flat;
              hash <= iv_flat;
            end else begin
              work <= hash;
            end
          end
        end
        ROUND: begin
          if (w_valid) begin
            work <= work_next;
            t    <= t + 6'd1;
            if (t == 6'd63) state <= FINAL;
          end
        end
        FINAL: begin
          hash  <= hash_sum;
          state <= DONE;
          if (last_latched) digest_valid <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign digest = digest_valid ? hash : '0;

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress
// Directed bench for sha256_compress: known-answer digests for "abc", the
// empty message and the two-block 448-bit message, plus stall, ignored-input
// and mid-block reset scenarios. The bench builds each block's word schedule
// itself from the padded message block.
module tb_sha256_compress;

  logic         clk;
  logic         reset;
  logic         block_start;
  logic         first_block;
  logic         last_block;
  logic         w_valid;
  logic [31:0]  w_in;
  logic         busy;
  logic         done;
  logic         digest_valid;
  logic [255:0] digest;

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] w_sched [0:63];

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_TWO_1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_2 = {480'd0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  sha256_compress dut (
    .clk          (clk),
    .reset        (reset),
    .block_start  (block_start),
    .first_block  (first_block),
    .last_block   (last_block),
    .w_valid      (w_valid),
    .w_in         (w_in),
    .busy         (busy),
    .done         (done),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic fill_schedule(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) w_sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w_sched[i] = ss1(w_sched[i-2]) + w_sched[i-7] + ss0(w_sched[i-15]) + w_sched[i-16];
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Runs one block starting in the current cycle (called #1 after a rising
  // edge while the DUT is idle). stalls: number of w_valid=0 gaps inserted.
  // noise: drive w_valid with junk in IDLE and on the block_start cycle.
  // poke: pulse block_start mid-ROUND. abort_at: assert reset when that many
  // words have been consumed (-1 disables).
  task automatic applyStimulus(input string tag, input logic [511:0] blk,
                               input logic first, input logic last,
                               input int stalls, input bit noise, input bit poke,
                               input int abort_at, input logic [255:0] exp_digest);
    int latency;
    int idx;
    int stalls_left;
    fill_schedule(blk);
    if (noise) begin
      w_valid = 1'b1;
      w_in    = 32'hdeadbeef;
      @(posedge clk); #1;
    end
    block_start = 1'b1;
    first_block = first;
    last_block  = last;
    w_valid     = noise;
    w_in        = 32'hcafef00d;
    @(posedge clk); #1;
    checkOutput({tag, "_busy_start"}, {255'd0, busy}, 256'd1);
    checkOutput({tag, "_dv_cleared"}, {255'd0, digest_valid}, 256'd0);
    latency     = 1;
    idx         = 0;
    stalls_left = stalls;
    while (!done && latency < 200) begin
      block_start = 1'b0;
      first_block = 1'b0;
      last_block  = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        w_valid = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput({tag, "_rst_busy"}, {255'd0, busy}, 256'd0);
        checkOutput({tag, "_rst_done"}, {255'd0, done}, 256'd0);
        checkOutput({tag, "_rst_dv"}, {255'd0, digest_valid}, 256'd0);
        checkOutput({tag, "_rst_digest"}, digest, 256'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (poke && idx == 10) begin
        block_start = 1'b1;
        first_block = 1'b1;
      end
      if (idx < 64) begin
        if (stalls_left > 0 && (idx == 63 || $urandom_range(0, 2) == 0)) begin
          w_valid = 1'b0;
          w_in    = 32'h0badf00d;
          stalls_left--;
        end else begin
          w_valid = 1'b1;
          w_in    = w_sched[idx];
          idx++;
        end
      end else begin
        w_valid = noise;
        w_in    = 32'h12345678;
      end
      @(posedge clk); #1;
      latency++;
    end
    block_start = 1'b0;
    first_block = 1'b0;
    last_block  = 1'b0;
    w_valid     = 1'b0;
    checkOutput({tag, "_latency"}, 256'(latency), 256'(66 + stalls));
    checkOutput({tag, "_done"}, {255'd0, done}, 256'd1);
    checkOutput({tag, "_busy_done"}, {255'd0, busy}, 256'd1);
    checkOutput({tag, "_dv"}, {255'd0, digest_valid}, {255'd0, last});
    checkOutput({tag, "_digest"}, digest, last ? exp_digest : 256'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, {255'd0, done}, 256'd0);
    checkOutput({tag, "_idle"}, {255'd0, busy}, 256'd0);
    checkOutput({tag, "_dv_hold"}, {255'd0, digest_valid}, {255'd0, last});
    checkOutput({tag, "_digest_hold"}, digest, last ? exp_digest : 256'd0);
  endtask

  initial begin
    reset       = 1'b1;
    block_start = 1'b0;
    first_block = 1'b0;
    last_block  = 1'b0;
    w_valid     = 1'b0;
    w_in        = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {255'd0, busy}, 256'd0);
    checkOutput("reset_done", {255'd0, done}, 256'd0);
    checkOutput("reset_dv", {255'd0, digest_valid}, 256'd0);
    checkOutput("reset_digest", digest, 256'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus("abc", BLK_ABC, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1, DIG_ABC);
    applyStimulus("empty", BLK_EMPTY, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1, DIG_EMPTY);
    applyStimulus("two_b1", BLK_TWO_1, 1'b1, 1'b0, 0, 1'b0, 1'b0, -1, DIG_TWO);
    applyStimulus("two_b2", BLK_TWO_2, 1'b0, 1'b1, 0, 1'b0, 1'b0, -1, DIG_TWO);
    applyStimulus("abc_stall", BLK_ABC, 1'b1, 1'b1, 20, 1'b0, 1'b0, -1, DIG_ABC);
    applyStimulus("abc_ignore", BLK_ABC, 1'b1, 1'b1, 0, 1'b1, 1'b1, -1, DIG_ABC);
    applyStimulus("abc_abort", BLK_ABC, 1'b1, 1'b1, 0, 1'b0, 1'b0, 30, DIG_ABC);
    applyStimulus("abc_fresh", BLK_ABC, 1'b1, 1'b1, 0, 1'b0, 1'b0, -1, DIG_ABC);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
